// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side definitions: exception codes, NOP encoding, fetch FSM states
// and the prefetch queue entry layout.
package fetch_queue_pkg;

    localparam int FQ_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [4:0] {
        EXC_CODE_INSTR_MISALIGN  = 5'd0,
        EXC_CODE_INST_PAGE_FAULT = 5'd12,
        EXC_CODE_NO_EXCEPTION    = 5'd31
    } type_exc_code_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XLATE    = 2'd1,
        WAIT_ACK = 2'd2,
        HALT     = 2'd3
    } type_fq_state_e;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic               exc_req;
        type_exc_code_e     exc_code;
    } type_fq_entry_s;

    localparam type_fq_entry_s FQ_ENTRY_EMPTY = '{
        pc:       '0,
        instr:    '0,
        exc_req:  1'b0,
        exc_code: EXC_CODE_NO_EXCEPTION
    };

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular prefetch FIFO of fetch entries; pointers carry an extra wrap bit so
// full and empty are distinguishable. Flush overrides push and pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  type_fq_entry_s               wdata,
    input  logic                         pop,
    input  logic                         flush,
    output type_fq_entry_s               head,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    type_fq_entry_s mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    used;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Push while full is only ever paired with a pop, so overwriting the head
    // slot at the edge is safe: the old head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign used      = wr_ptr - rd_ptr;
    assign count     = CW'(used);
    assign not_empty = (used != '0);
    assign head      = not_empty ? mem[rd_ptr[AW-1:0]] : FQ_ENTRY_EMPTY;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, sequences MMU translation and I-cache requests,
// and feeds ID from a prefetch FIFO. Redirects flush the queue and kill requests.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [XLEN-1:0]             mmu_vaddr_o,
    input  logic                        mmu_hit_i,
    input  logic [XLEN-1:0]             mmu_paddr_i,
    input  logic                        mmu_page_fault_i,
    output logic                        ic_req_o,
    output logic [XLEN-1:0]             ic_addr_o,
    output logic                        ic_kill_o,
    input  logic                        ic_ack_i,
    input  logic [31:0]                 ic_rdata_i,
    input  logic                        csr_redirect_i,
    input  logic [XLEN-1:0]             csr_pc_i,
    input  logic                        exe_redirect_i,
    input  logic [XLEN-1:0]             exe_pc_i,
    output logic                        id_valid_o,
    input  logic                        id_ready_i,
    output logic [31:0]                 id_instr_o,
    output logic [XLEN-1:0]             id_pc_o,
    output logic                        id_exc_req_o,
    output type_exc_code_e              id_exc_code_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output type_fq_state_e              state_o
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

    type_fq_state_e  state, state_next;
    logic [XLEN-1:0] fpc, fpc_next;
    logic [XLEN-1:0] ic_addr;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect;
    logic            push, pop, latch_paddr;
    logic            head_valid;
    logic            room_idle, room_after_ack;
    logic [CW-1:0]   count;
    type_fq_entry_s  push_entry, head;

    // Valid/ready toward ID: the head transfers on a cycle where id_valid_o and
    // id_ready_i are both high; the head holds steady while valid and not ready.
    assign redirect    = csr_redirect_i | exe_redirect_i;
    assign redirect_pc = csr_redirect_i ? csr_pc_i : exe_pc_i;
    assign pop         = head_valid & id_ready_i & ~redirect;

    // A slot is reserved before translation starts, so WAIT_ACK never overflows.
    assign room_idle      = {1'b0, count} < DEPTH_W;
    assign room_after_ack = ({1'b0, count} + (CW + 1)'(1)) < (DEPTH_W + {{CW{1'b0}}, pop});

    always_comb begin
        state_next  = state;
        fpc_next    = fpc;
        push        = 1'b0;
        latch_paddr = 1'b0;
        push_entry  = '{pc: fpc, instr: INSTR_NOP, exc_req: 1'b0, exc_code: EXC_CODE_NO_EXCEPTION};
        case (state)
            IDLE: begin
                if (room_idle) state_next = XLATE;
            end
            XLATE: begin
                if (fpc[1:0] != 2'b00) begin
                    push                = 1'b1;
                    push_entry.exc_req  = 1'b1;
                    push_entry.exc_code = EXC_CODE_INSTR_MISALIGN;
                    state_next          = HALT;
                end else if (mmu_page_fault_i) begin
                    push                = 1'b1;
                    push_entry.exc_req  = 1'b1;
                    push_entry.exc_code = EXC_CODE_INST_PAGE_FAULT;
                    state_next          = HALT;
                end else if (mmu_hit_i) begin
                    latch_paddr = 1'b1;
                    state_next  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ic_ack_i) begin
                    push             = 1'b1;
                    push_entry.instr = ic_rdata_i;
                    fpc_next         = fpc + XLEN'(4);
                    state_next       = room_after_ack ? XLATE : IDLE;
                end
            end
            HALT: ;
            default: state_next = IDLE;
        endcase
        // The flushed queue always has room, so a redirect starts translating at once.
        if (redirect) begin
            push        = 1'b0;
            latch_paddr = 1'b0;
            fpc_next    = redirect_pc;
            state_next  = XLATE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            fpc     <= PC_RESET;
            ic_addr <= '0;
        end else begin
            state <= state_next;
            fpc   <= fpc_next;
            if (latch_paddr) ic_addr <= mmu_paddr_i;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .not_empty (head_valid),
        .count     (count)
    );

    assign mmu_vaddr_o   = fpc;
    assign ic_req_o      = (state == WAIT_ACK);
    assign ic_addr_o     = ic_addr;
    assign ic_kill_o     = redirect & (state == WAIT_ACK);
    assign id_valid_o    = head_valid;
    assign id_instr_o    = head.instr;
    assign id_pc_o       = head.pc;
    assign id_exc_req_o  = head.exc_req;
    assign id_exc_code_o = head.exc_code;
    assign count_o       = count;
    assign state_o       = state;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: expected-entry queue model of the delivered stream,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam int          EW       = $bits(type_fq_entry_s);

    logic clk, rst;
    logic [31:0] mmu_vaddr_o, mmu_paddr_i, ic_addr_o, ic_rdata_i;
    logic [31:0] csr_pc_i, exe_pc_i, id_instr_o, id_pc_o;
    logic mmu_hit_i, mmu_page_fault_i, ic_req_o, ic_kill_o, ic_ack_i;
    logic csr_redirect_i, exe_redirect_i, id_valid_o, id_ready_i, id_exc_req_o;
    type_exc_code_e id_exc_code_o;
    logic [2:0] count_o;
    type_fq_state_e state_o;

    logic auto_ack;
    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  popped_q[$];
    logic [31:0]    model_pc;
    type_fq_entry_s pend_e, cmp_e, pop_e;
    logic           pend_v;

    function automatic logic [31:0] tb_xlate(input logic [31:0] v);
        return v ^ 32'h0F00_0000;
    endfunction

    function automatic logic [31:0] tb_data(input logic [31:0] p);
        return {p[15:0], ~p[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic type_fq_entry_s mk(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic exc, input type_exc_code_e code);
        return '{pc: pc, instr: instr, exc_req: exc, exc_code: code};
    endfunction

    assign mmu_paddr_i = tb_xlate(mmu_vaddr_o);

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst(rst),
        .mmu_vaddr_o(mmu_vaddr_o), .mmu_hit_i(mmu_hit_i), .mmu_paddr_i(mmu_paddr_i),
        .mmu_page_fault_i(mmu_page_fault_i),
        .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_kill_o(ic_kill_o),
        .ic_ack_i(ic_ack_i), .ic_rdata_i(ic_rdata_i),
        .csr_redirect_i(csr_redirect_i), .csr_pc_i(csr_pc_i),
        .exe_redirect_i(exe_redirect_i), .exe_pc_i(exe_pc_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
        .id_pc_o(id_pc_o), .id_exc_req_o(id_exc_req_o), .id_exc_code_o(id_exc_code_o),
        .count_o(count_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic c, input logic [31:0] cpc, input logic e, input logic [31:0] epc);
        csr_redirect_i = c;
        csr_pc_i       = cpc;
        exe_redirect_i = e;
        exe_pc_i       = epc;
        tick();
        csr_redirect_i = 1'b0;
        exe_redirect_i = 1'b0;
    endtask

    // I-cache responder: acks in the first cycle it sees a request.
    always @(posedge clk) begin
        #1;
        ic_ack_i   = auto_ack && ic_req_o;
        ic_rdata_i = tb_data(ic_addr_o);
    end

    // ---------------- behavioural model ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            model_pc = PC_RESET;
            pend_v   = 1'b0;
        end else if (csr_redirect_i || exe_redirect_i) begin
            exp_q.delete();
            pend_v   = 1'b0;
            model_pc = csr_redirect_i ? csr_pc_i : exe_pc_i;
            if (model_pc[1:0] != 2'b00) begin
                pend_e = mk(model_pc, INSTR_NOP, 1'b1, EXC_CODE_INSTR_MISALIGN);
                pend_v = 1'b1;
            end else if (mmu_page_fault_i) begin
                pend_e = mk(model_pc, INSTR_NOP, 1'b1, EXC_CODE_INST_PAGE_FAULT);
                pend_v = 1'b1;
            end
        end else begin
            if (exp_q.size() != 0 && id_ready_i) begin
                popped_q.push_back(exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (pend_v) begin
                exp_q.push_back(pend_e);
                pend_v = 1'b0;
            end
            if (ic_ack_i) begin
                exp_q.push_back(mk(model_pc, tb_data(tb_xlate(model_pc)), 1'b0, EXC_CODE_NO_EXCEPTION));
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("count", 64'(count_o), 64'(exp_q.size()));
            check("valid", 64'(id_valid_o), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                cmp_e = exp_q[0];
                check("head_pc", 64'(id_pc_o), 64'(cmp_e.pc));
                check("head_instr", 64'(id_instr_o), 64'(cmp_e.instr));
                check("head_exc_req", 64'(id_exc_req_o), 64'(cmp_e.exc_req));
                check("head_exc_code", 64'(id_exc_code_o), 64'(cmp_e.exc_code));
            end
            if (exp_q.size() == DEPTH) check("req_when_full", 64'(ic_req_o), 64'd0);
            if (!csr_redirect_i && !exe_redirect_i) check("kill_no_redirect", 64'(ic_kill_o), 64'd0);
            check("count_bound", 64'(count_o <= 3'(DEPTH)), 64'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int budget;
        int base;
        logic ok;

        rst = 1'b1;
        mmu_hit_i = 1'b1;
        mmu_page_fault_i = 1'b0;
        ic_ack_i = 1'b0;
        ic_rdata_i = '0;
        csr_redirect_i = 1'b0;
        exe_redirect_i = 1'b0;
        csr_pc_i = '0;
        exe_pc_i = '0;
        id_ready_i = 1'b1;
        auto_ack = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_vaddr", 64'(mmu_vaddr_o), 64'(PC_RESET));
        check("rst_req", 64'(ic_req_o), 64'd0);
        check("rst_addr", 64'(ic_addr_o), 64'd0);
        check("rst_valid", 64'(id_valid_o), 64'd0);
        check("rst_pc", 64'(id_pc_o), 64'd0);
        check("rst_instr", 64'(id_instr_o), 64'd0);
        check("rst_exc_code", 64'(id_exc_code_o), 64'(EXC_CODE_NO_EXCEPTION));
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_state", 64'(state_o), 64'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // In-order delivery from reset
        ok = 1'b0;
        for (budget = 0; budget < 60 && !ok; budget++) begin
            tick();
            ok = (popped_q.size() >= 3);
        end
        check("wait_first_three", 64'(ok), 64'd1);
        if (ok) begin
            pop_e = popped_q[0];
            check("deliver0_pc", 64'(pop_e.pc), 64'h8000_0000);
            check("deliver0_instr", 64'(pop_e.instr), 64'h1357_6420);
            pop_e = popped_q[1];
            check("deliver1_pc", 64'(pop_e.pc), 64'h8000_0004);
            pop_e = popped_q[2];
            check("deliver2_pc", 64'(pop_e.pc), 64'h8000_0008);
        end

        // Backpressure fills the queue, release drains back-to-back
        id_ready_i = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("full_count", 64'(count_o), 64'd4);
        check("full_no_req", 64'(ic_req_o), 64'd0);
        tick();
        id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_valid", 64'(id_valid_o), 64'd1);
            check("drain_count", 64'(count_o), 64'(4 - i));
            if (i == 3) check("resume_req", 64'(ic_req_o), 64'd1);
            tick();
        end
        repeat (6) tick();

        // Misaligned redirect target halts after one exception entry
        id_ready_i = 1'b0;
        redirect(1'b0, 32'h0, 1'b1, 32'h8000_0102);
        @(negedge clk);
        check("mis_vaddr", 64'(mmu_vaddr_o), 64'h8000_0102);
        check("mis_state_xlate", 64'(state_o), 64'(XLATE));
        tick();
        @(negedge clk);
        check("mis_count", 64'(count_o), 64'd1);
        check("mis_pc", 64'(id_pc_o), 64'h8000_0102);
        check("mis_exc", 64'(id_exc_req_o), 64'd1);
        check("mis_code", 64'(id_exc_code_o), 64'(EXC_CODE_INSTR_MISALIGN));
        check("mis_instr", 64'(id_instr_o), 64'(INSTR_NOP));
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("halt_state", 64'(state_o), 64'(HALT));
            check("halt_no_req", 64'(ic_req_o), 64'd0);
        end
        tick();

        // Page fault during translation
        mmu_hit_i = 1'b0;
        mmu_page_fault_i = 1'b1;
        redirect(1'b0, 32'h0, 1'b1, 32'h8000_1000);
        tick();
        @(negedge clk);
        check("pf_count", 64'(count_o), 64'd1);
        check("pf_pc", 64'(id_pc_o), 64'h8000_1000);
        check("pf_exc", 64'(id_exc_req_o), 64'd1);
        check("pf_code", 64'(id_exc_code_o), 64'(EXC_CODE_INST_PAGE_FAULT));
        check("pf_instr", 64'(id_instr_o), 64'(INSTR_NOP));
        check("pf_no_req", 64'(ic_req_o), 64'd0);
        check("pf_state", 64'(state_o), 64'(HALT));
        tick();
        mmu_hit_i = 1'b1;
        mmu_page_fault_i = 1'b0;

        // Redirect colliding with an ack while two entries are queued
        redirect(1'b0, 32'h0, 1'b1, 32'h8000_0400);
        ok = 1'b0;
        for (budget = 0; budget < 40 && !ok; budget++) begin
            ok = (count_o == 3'd2) && ic_req_o;
            if (!ok) tick();
        end
        check("wait_two_queued", 64'(ok), 64'd1);
        exe_redirect_i = 1'b1;
        exe_pc_i = 32'h8000_0500;
        @(negedge clk);
        check("collide_ack", 64'(ic_ack_i), 64'd1);
        check("collide_kill", 64'(ic_kill_o), 64'd1);
        tick();
        exe_redirect_i = 1'b0;
        @(negedge clk);
        check("collide_count", 64'(count_o), 64'd0);
        id_ready_i = 1'b1;
        ok = 1'b0;
        for (budget = 0; budget < 20 && !ok; budget++) begin
            tick();
            ok = id_valid_o;
        end
        check("wait_after_collide", 64'(ok), 64'd1);
        check("collide_next_pc", 64'(id_pc_o), 64'h8000_0500);
        check("collide_next_instr", 64'(id_instr_o), 64'h1657_6120);
        repeat (5) tick();

        // Simultaneous redirects: CSR wins; redirect-to-delivery latency
        redirect(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300);
        @(negedge clk);
        check("both_vaddr", 64'(mmu_vaddr_o), 64'h8000_0200);
        check("both_state", 64'(state_o), 64'(XLATE));
        tick();
        @(negedge clk);
        check("both_req_t2", 64'(ic_req_o), 64'd1);
        check("both_addr", 64'(ic_addr_o), 64'h8F00_0200);
        tick();
        @(negedge clk);
        check("both_valid_t3", 64'(id_valid_o), 64'd1);
        check("both_pc", 64'(id_pc_o), 64'h8000_0200);
        repeat (8) tick();

        // Asynchronous reset in the middle of a request
        ok = 1'b0;
        for (budget = 0; budget < 10 && !ok; budget++) begin
            ok = ic_req_o;
            if (!ok) tick();
        end
        check("wait_req_before_rst", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 64'(ic_req_o), 64'd0);
        check("arst_vaddr", 64'(mmu_vaddr_o), 64'(PC_RESET));
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(id_valid_o), 64'd0);
        check("arst_addr", 64'(ic_addr_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = popped_q.size();
        ok = 1'b0;
        for (budget = 0; budget < 20 && !ok; budget++) begin
            tick();
            ok = (popped_q.size() > base);
        end
        check("wait_after_arst", 64'(ok), 64'd1);
        if (ok) begin
            pop_e = popped_q[base];
            check("arst_first_pc", 64'(pop_e.pc), 64'(PC_RESET));
        end
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
